// File: rtl/dbg_axi_pkg.sv
// rtl/dbg_axi_pkg.sv - shared types and constants for the debug AXI master
package dbg_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_RSP     = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] ADDR_UART_TX        = 32'h6000_0000;
  localparam logic [31:0] ADDR_TIMER          = 32'h6000_0008;
  localparam logic [31:0] ADDR_COTRL          = 32'h6000_0010;
  localparam logic [31:0] ADDR_COTRL_COREMARK = 32'h6000_0020;

  // One buffered core request; 73 bits wide.
  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  id;
  } req_t;

  localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/dbg_axi_master_if.sv
// rtl/dbg_axi_master_if.sv - core request/response and AXI4-lite signal bundle
interface dbg_axi_master_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [3:0]  req_id;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  rsp_id;
  logic        rsp_wen;
  logic        id_err;

  logic [3:0]  M_AWID;
  logic [31:0] M_AWADDR;
  logic        M_AWVALID;
  logic        M_AWREADY;
  logic [31:0] M_WDATA;
  logic [3:0]  M_WSTRB;
  logic        M_WVALID;
  logic        M_WREADY;
  logic [3:0]  M_BID;
  logic [1:0]  M_BRESP;
  logic        M_BVALID;
  logic        M_BREADY;
  logic [3:0]  M_ARID;
  logic [31:0] M_ARADDR;
  logic        M_ARVALID;
  logic        M_ARREADY;
  logic [3:0]  M_RID;
  logic [31:0] M_RDATA;
  logic [1:0]  M_RRESP;
  logic        M_RVALID;
  logic        M_RREADY;

  modport master (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, req_id,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_resp, rsp_id, rsp_wen, id_err,
    input  rsp_ready,
    output M_AWID, M_AWADDR, M_AWVALID, input M_AWREADY,
    output M_WDATA, M_WSTRB, M_WVALID, input M_WREADY,
    input  M_BID, M_BRESP, M_BVALID, output M_BREADY,
    output M_ARID, M_ARADDR, M_ARVALID, input M_ARREADY,
    input  M_RID, M_RDATA, M_RRESP, M_RVALID, output M_RREADY
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb, req_id,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_resp, rsp_id, rsp_wen, id_err,
    output rsp_ready,
    input  M_AWID, M_AWADDR, M_AWVALID, output M_AWREADY,
    input  M_WDATA, M_WSTRB, M_WVALID, output M_WREADY,
    output M_BID, M_BRESP, M_BVALID, input M_BREADY,
    input  M_ARID, M_ARADDR, M_ARVALID, output M_ARREADY,
    output M_RID, M_RDATA, M_RRESP, M_RVALID, input M_RREADY
  );

endinterface

// File: rtl/dbg_req_fifo.sv
// rtl/dbg_req_fifo.sv - synchronous request FIFO with wrap-bit full/empty detection
module dbg_req_fifo #(
  parameter int DW = 73,
  parameter int DP = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] head_o
);

  localparam int AW = $clog2(DP);

  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic [DW-1:0] mem_q [DP];
  logic          do_push;
  logic          do_pop;

  // Same slot index with differing wrap bits means the writer lapped the reader.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/dbg_axi_master.sv
// rtl/dbg_axi_master.sv - core request stream to single-outstanding AXI4-lite master
module dbg_axi_master
  import dbg_axi_pkg::*;
#(
  parameter int FIFO_DP = 4,
  parameter int TMO_CYC = 1024
) (
  input logic              CLK,
  input logic              RSTn,
  dbg_axi_master_if.master bus
);

  localparam bit          TMO_EN   = (TMO_CYC != 0);
  localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TMO_CYC - 1) : 32'd0;

  state_e      state_q, state_d;
  req_t        txn_q, txn_d;
  req_t        req_in, fifo_head;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  resp_q, resp_d;
  logic        id_err_q, id_err_d;
  logic        aw_hs, w_hs, tmo_hit;

  assign req_in = {bus.req_wen, bus.req_addr, bus.req_wdata, bus.req_wstrb, bus.req_id};

  dbg_req_fifo #(
    .DW(REQ_W),
    .DP(FIFO_DP)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_ni     (RSTn),
    .push_i     (bus.req_valid),
    .push_data_i(req_in),
    .pop_i      (fifo_pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (fifo_head)
  );

  assign aw_hs   = bus.M_AWVALID && bus.M_AWREADY;
  assign w_hs    = bus.M_WVALID && bus.M_WREADY;
  assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    txn_d     = txn_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    tmo_d     = tmo_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    id_err_d  = id_err_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          txn_d     = fifo_head;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          tmo_d     = '0;
          state_d   = fifo_head.wen ? ST_WR_AW_W : ST_RD_AR;
        end
      end
      ST_WR_AW_W: begin
        // AW and W complete independently; each valid drops once its own beat is taken.
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) state_d = ST_WR_B;
      end
      ST_WR_B: begin
        if (bus.M_BVALID) begin
          resp_d  = bus.M_BRESP;
          rdata_d = '0;
          if (bus.M_BID != txn_q.id) id_err_d = 1'b1;
          state_d = ST_RSP;
        end else if (tmo_hit) begin
          resp_d  = RESP_SLVERR;
          rdata_d = '0;
          state_d = ST_RSP;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      ST_RD_AR: begin
        if (bus.M_ARREADY) state_d = ST_RD_R;
      end
      ST_RD_R: begin
        if (bus.M_RVALID) begin
          resp_d  = bus.M_RRESP;
          rdata_d = bus.M_RDATA;
          if (bus.M_RID != txn_q.id) id_err_d = 1'b1;
          state_d = ST_RSP;
        end else if (tmo_hit) begin
          resp_d  = RESP_SLVERR;
          rdata_d = '0;
          state_d = ST_RSP;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      ST_RSP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= ST_IDLE;
      txn_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      tmo_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      id_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      txn_q     <= txn_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      tmo_q     <= tmo_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      id_err_q  <= id_err_d;
    end
  end

  // All bus controls decode from registered state so reset clears them immediately.
  assign bus.req_ready = !fifo_full;

  assign bus.M_AWID    = txn_q.id;
  assign bus.M_AWADDR  = txn_q.addr;
  assign bus.M_AWVALID = (state_q == ST_WR_AW_W) && !aw_done_q;
  assign bus.M_WDATA   = txn_q.wdata;
  assign bus.M_WSTRB   = txn_q.wstrb;
  assign bus.M_WVALID  = (state_q == ST_WR_AW_W) && !w_done_q;
  assign bus.M_BREADY  = (state_q == ST_WR_B);
  assign bus.M_ARID    = txn_q.id;
  assign bus.M_ARADDR  = txn_q.addr;
  assign bus.M_ARVALID = (state_q == ST_RD_AR);
  assign bus.M_RREADY  = (state_q == ST_RD_R);

  assign bus.rsp_valid = (state_q == ST_RSP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_resp  = resp_q;
  assign bus.rsp_id    = txn_q.id;
  assign bus.rsp_wen   = txn_q.wen;
  assign bus.id_err    = id_err_q;

endmodule

// File: tb/tb_dbg_axi_master.sv
// tb/tb_dbg_axi_master.sv - directed table-driven bench for dbg_axi_master
module tb_dbg_axi_master;
  import dbg_axi_pkg::*;

  localparam int TMO = 16;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;

  dbg_axi_master_if bus();

  dbg_axi_master #(.FIFO_DP(4), .TMO_CYC(TMO)) dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave behaviour knobs, set by the main sequence before each request.
  int          sl_w_extra = 0;
  int          sl_dly     = 0;
  logic [3:0]  sl_id_xor  = 4'h0;
  logic [1:0]  sl_resp    = 2'b00;
  logic [31:0] sl_rdata   = 32'h0;
  bit          sl_silent  = 1'b0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  int rdy_cyc = 0;
  always @(negedge CLK) if (bus.M_BREADY || bus.M_RREADY) rdy_cyc <= rdy_cyc + 1;

  task automatic slave_write();
    logic [3:0] id;
    id       = bus.M_AWID;
    cap_addr = bus.M_AWADDR;
    bus.M_AWREADY = 1'b1;
    bus.M_WREADY  = (sl_w_extra == 0);
    if (sl_w_extra == 0) begin
      cap_wdata = bus.M_WDATA;
      cap_wstrb = bus.M_WSTRB;
    end
    @(negedge CLK);
    bus.M_AWREADY = 1'b0;
    bus.M_WREADY  = 1'b0;
    if (sl_w_extra != 0) begin
      check("skew_awvalid_dropped", 32'(bus.M_AWVALID), 0);
      repeat (sl_w_extra - 1) @(negedge CLK);
      check("skew_wvalid_held", 32'(bus.M_WVALID), 1);
      cap_wdata = bus.M_WDATA;
      cap_wstrb = bus.M_WSTRB;
      bus.M_WREADY = 1'b1;
      @(negedge CLK);
      bus.M_WREADY = 1'b0;
    end
    if (!sl_silent) begin
      repeat (sl_dly) @(negedge CLK);
      bus.M_BID    = id ^ sl_id_xor;
      bus.M_BRESP  = sl_resp;
      bus.M_BVALID = 1'b1;
      for (int i = 0; i < 64 && !bus.M_BREADY; i++) @(negedge CLK);
      @(negedge CLK);
      bus.M_BVALID = 1'b0;
      check("bready_dropped", 32'(bus.M_BREADY), 0);
    end
  endtask

  task automatic slave_read();
    logic [3:0] id;
    id       = bus.M_ARID;
    cap_addr = bus.M_ARADDR;
    if (sl_dly != 0) begin
      repeat (sl_dly) @(negedge CLK);
      check("arvalid_held", 32'(bus.M_ARVALID), 1);
    end
    bus.M_ARREADY = 1'b1;
    @(negedge CLK);
    bus.M_ARREADY = 1'b0;
    if (!sl_silent) begin
      bus.M_RID    = id ^ sl_id_xor;
      bus.M_RDATA  = sl_rdata;
      bus.M_RRESP  = sl_resp;
      bus.M_RVALID = 1'b1;
      for (int i = 0; i < 64 && !bus.M_RREADY; i++) @(negedge CLK);
      @(negedge CLK);
      bus.M_RVALID = 1'b0;
      check("rready_dropped", 32'(bus.M_RREADY), 0);
    end
  endtask

  initial begin : slave
    bus.M_AWREADY = 1'b0; bus.M_WREADY = 1'b0; bus.M_ARREADY = 1'b0;
    bus.M_BVALID  = 1'b0; bus.M_BID = 4'h0; bus.M_BRESP = 2'b00;
    bus.M_RVALID  = 1'b0; bus.M_RID = 4'h0; bus.M_RRESP = 2'b00; bus.M_RDATA = 32'h0;
    forever begin
      @(negedge CLK);
      if (RSTn && bus.M_AWVALID) slave_write();
      else if (RSTn && bus.M_ARVALID) slave_read();
    end
  end

  task automatic push(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic [3:0] id);
    bus.req_wen = wen; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_wstrb = wstrb; bus.req_id = id; bus.req_valid = 1'b1;
    for (int i = 0; i < 100 && !bus.req_ready; i++) @(negedge CLK);
    check("push_accepted", 32'(bus.req_ready), 1);
    @(negedge CLK);
    bus.req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold, output logic [31:0] rdata, output logic [1:0] resp,
                         output logic [3:0] id, output logic wen);
    for (int i = 0; i < 200 && !bus.rsp_valid; i++) @(negedge CLK);
    check("rsp_valid_seen", 32'(bus.rsp_valid), 1);
    rdata = bus.rsp_rdata; resp = bus.rsp_resp; id = bus.rsp_id; wen = bus.rsp_wen;
    for (int k = 0; k < hold; k++) begin
      @(negedge CLK);
      check("rsp_hold_valid", 32'(bus.rsp_valid), 1);
      check("rsp_hold_payload", {bus.rsp_rdata[24:0], bus.rsp_resp, bus.rsp_id, bus.rsp_wen},
            {rdata[24:0], resp, id, wen});
    end
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  id;
    int          w_extra;
    int          dly;
    logic [3:0]  id_xor;
    logic [1:0]  resp;
    logic [31:0] rdata;
    bit          silent;
    int          hold;
    logic [31:0] e_rdata;
    logic [1:0]  e_resp;
    logic        e_iderr;
  } vec_t;

  initial begin : main
    vec_t        tbl[8];
    logic [31:0] r_rdata;
    logic [1:0]  r_resp;
    logic [3:0]  r_id;
    logic        r_wen;
    int          rc0;
    bit          busy_seen;

    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0; bus.req_wstrb = 4'h0; bus.req_id = 4'h0;
    bus.rsp_ready = 1'b0;

    //           wen   addr                 wdata          strb  id    wx dly xor   resp         rdata          sil hold e_rdata        e_resp       e_iderr
    tbl[0] = '{1'b1, ADDR_UART_TX,        32'h0000_0041, 4'hF, 4'h3, 0, 0, 4'h0, RESP_OKAY,   32'h0,         0, 3, 32'h0,         RESP_OKAY,   1'b0};
    tbl[1] = '{1'b1, ADDR_COTRL,          32'h1234_5678, 4'h3, 4'h6, 2, 1, 4'h0, RESP_OKAY,   32'h0,         0, 0, 32'h0,         RESP_OKAY,   1'b0};
    tbl[2] = '{1'b0, ADDR_TIMER,          32'h0,         4'h0, 4'h5, 0, 0, 4'h0, RESP_OKAY,   32'hDEAD_BEEF, 0, 2, 32'hDEAD_BEEF, RESP_OKAY,   1'b0};
    tbl[3] = '{1'b0, ADDR_COTRL_COREMARK, 32'h0,         4'h0, 4'h9, 0, 2, 4'h0, RESP_SLVERR, 32'hCAFE_0001, 0, 0, 32'hCAFE_0001, RESP_SLVERR, 1'b0};
    tbl[4] = '{1'b1, ADDR_UART_TX,        32'h0000_0042, 4'h1, 4'h2, 0, 0, 4'h5, RESP_OKAY,   32'h0,         0, 0, 32'h0,         RESP_OKAY,   1'b1};
    tbl[5] = '{1'b1, ADDR_TIMER,          32'h0000_0055, 4'hF, 4'h4, 0, 0, 4'h0, RESP_OKAY,   32'h0,         1, 0, 32'h0,         RESP_SLVERR, 1'b1};
    tbl[6] = '{1'b0, ADDR_COTRL,          32'h0,         4'h0, 4'hA, 0, 0, 4'h0, RESP_OKAY,   32'h1111_2222, 1, 0, 32'h0,         RESP_SLVERR, 1'b1};
    tbl[7] = '{1'b1, ADDR_COTRL_COREMARK, 32'hFFFF_0000, 4'hC, 4'hF, 1, 2, 4'h0, 2'b01,       32'h0,         0, 1, 32'h0,         2'b01,       1'b1};

    repeat (3) @(negedge CLK);
    check("rst_ctrl_low", 32'({bus.M_AWVALID, bus.M_WVALID, bus.M_ARVALID, bus.M_BREADY,
                               bus.M_RREADY, bus.rsp_valid, bus.id_err}), 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_resp", 32'(bus.rsp_resp), 0);
    check("rst_req_ready", 32'(bus.req_ready), 1);
    RSTn = 1'b1;
    @(negedge CLK);

    for (int v = 0; v < 8; v++) begin
      sl_w_extra = tbl[v].w_extra; sl_dly = tbl[v].dly; sl_id_xor = tbl[v].id_xor;
      sl_resp = tbl[v].resp; sl_rdata = tbl[v].rdata; sl_silent = tbl[v].silent;
      rc0 = rdy_cyc;
      push(tbl[v].wen, tbl[v].addr, tbl[v].wdata, tbl[v].wstrb, tbl[v].id);
      get_rsp(tbl[v].hold, r_rdata, r_resp, r_id, r_wen);
      check($sformatf("v%0d_rdata", v), r_rdata, tbl[v].e_rdata);
      check($sformatf("v%0d_resp", v), 32'(r_resp), 32'(tbl[v].e_resp));
      check($sformatf("v%0d_id", v), 32'(r_id), 32'(tbl[v].id));
      check($sformatf("v%0d_wen", v), 32'(r_wen), 32'(tbl[v].wen));
      check($sformatf("v%0d_id_err", v), 32'(bus.id_err), 32'(tbl[v].e_iderr));
      check($sformatf("v%0d_bus_addr", v), cap_addr, tbl[v].addr);
      if (tbl[v].wen) begin
        check($sformatf("v%0d_bus_wdata", v), cap_wdata, tbl[v].wdata);
        check($sformatf("v%0d_bus_wstrb", v), 32'(cap_wstrb), 32'(tbl[v].wstrb));
      end
      if (tbl[v].silent) check($sformatf("v%0d_timeout_cycles", v), 32'(rdy_cyc - rc0), TMO);
      repeat (2) @(negedge CLK);
    end

    // Backpressure: five requests, responses held off, FIFO must fill at four.
    sl_w_extra = 0; sl_dly = 0; sl_id_xor = 4'h0; sl_resp = RESP_OKAY;
    sl_rdata = 32'h0BAD_F00D; sl_silent = 1'b0;
    for (int k = 1; k <= 5; k++) push(k[0], ADDR_UART_TX + 32'(k * 4), 32'(k), 4'hF, 4'(k));
    check("fifo_full_ready_low", 32'(bus.req_ready), 0);
    for (int k = 1; k <= 5; k++) begin
      get_rsp(0, r_rdata, r_resp, r_id, r_wen);
      check($sformatf("fifo_rsp%0d_id", k), 32'(r_id), 32'(k));
      check($sformatf("fifo_rsp%0d_wen", k), 32'(r_wen), 32'(k[0]));
      check($sformatf("fifo_rsp%0d_rdata", k), r_rdata, k[0] ? 32'h0 : 32'h0BAD_F00D);
      check($sformatf("fifo_rsp%0d_resp", k), 32'(r_resp), 0);
    end
    check("fifo_ready_restored", 32'(bus.req_ready), 1);
    repeat (2) @(negedge CLK);

    // Reset while waiting on B with a second request still buffered.
    sl_silent = 1'b1;
    push(1'b1, ADDR_TIMER, 32'h77, 4'hF, 4'h8);
    push(1'b0, ADDR_UART_TX, 32'h0, 4'h0, 4'h9);
    for (int i = 0; i < 100 && !bus.M_BREADY; i++) @(negedge CLK);
    check("pre_reset_bready", 32'(bus.M_BREADY), 1);
    RSTn = 1'b0;
    #1;
    check("reset_ctrl_low", 32'({bus.M_AWVALID, bus.M_WVALID, bus.M_ARVALID, bus.M_BREADY,
                                 bus.M_RREADY, bus.rsp_valid, bus.id_err}), 0);
    check("reset_req_ready", 32'(bus.req_ready), 1);
    @(negedge CLK);
    RSTn = 1'b1;
    busy_seen = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (bus.M_AWVALID || bus.M_ARVALID || bus.rsp_valid) busy_seen = 1'b1;
    end
    check("reset_fifo_flushed", 32'(busy_seen), 0);
    sl_silent = 1'b0;
    push(1'b1, ADDR_COTRL, 32'h99, 4'hF, 4'h1);
    get_rsp(0, r_rdata, r_resp, r_id, r_wen);
    check("post_reset_id", 32'(r_id), 1);
    check("post_reset_resp", 32'(r_resp), 0);
    check("post_reset_wen", 32'(r_wen), 1);
    check("post_reset_id_err", 32'(bus.id_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/dbg_axi_master.md
Name: dbg_axi_master

Overview:
- Upstream neighbour of the testbench debug slave: converts a simple core-side request stream (load/store with id) into 32-bit AXI4-lite-style AW/W/B and AR/R handshakes with 4-bit IDs.
- Buffers requests in a small FIFO and keeps at most one bus transaction outstanding.
- Returns one response per request on a valid/ready response port.
- Flags ID mismatches and timeouts so the bench can stop on protocol faults.

Parameters:
- FIFO_DP, 4, request FIFO depth; power of two, ≥2.
- TMO_CYC, 1024, cycles waiting on BVALID/RVALID before timeout; 0 disables timeout.

Ports:
- CLK  in  1  clock
- RSTn  in  1  asynchronous active-low reset
- req_valid/req_ready  in/out  1/1  request handshake
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_wstrb  in  4  write strobes
- req_id  in  4  transaction id
- rsp_valid/rsp_ready  out/in  1/1  response handshake
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP; 2'b10 on timeout
- rsp_id  out  4  id of the completed request
- rsp_wen  out  1  echoes req_wen
- id_err  out  1  sticky: returned BID/RID differed from the issued id
- M_AWID[4] M_AWADDR[32] M_AWVALID out; M_AWREADY in
- M_WDATA[32] M_WSTRB[4] M_WVALID out; M_WREADY in
- M_BID[4] M_BRESP[2] M_BVALID in; M_BREADY out
- M_ARID[4] M_ARADDR[32] M_ARVALID out; M_ARREADY in
- M_RID[4] M_RDATA[32] M_RRESP[2] M_RVALID in; M_RREADY out

Behaviour:
- Reset: FIFO empty; state IDLE; all M_*VALID, M_BREADY, M_RREADY, rsp_valid and id_err = 0; rsp_* data = 0; timeout counter = 0. Reset mid-transaction abandons it; no response is emitted.
- FIFO:
  - req_ready = ~full.
  - Push on req_valid & req_ready.
  - Pop only on the IDLE→issue transition.
  - Push and pop in the same cycle when full is not allowed because ready is low; when neither full nor empty, both occur and count is unchanged.
  - Pointers wrap modulo FIFO_DP; an extra bit distinguishes full from empty.
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE: if FIFO non-empty, pop the head into the transaction register (minimum one cycle from push to bus), then go to WR_AW_W or RD_AR.
- WR_AW_W:
  - Assert M_AWVALID and M_WVALID together in the same cycle. The slave raises AWREADY only when both valids are high.
  - Track aw_done and w_done independently. Drop each valid the cycle after its handshake; AW and W may complete in either order or together.
  - When both are done, go to WR_B.
- WR_B:
  - M_BREADY = 1.
  - On M_BVALID: capture BRESP; set id_err if BID != issued id; go to RSP.
- RD_AR: hold M_ARVALID until M_ARREADY, then go to RD_R.
- RD_R:
  - M_RREADY = 1.
  - On M_RVALID: capture RDATA/RRESP; check RID; go to RSP.
- Timeout: in WR_B/RD_R the counter increments each cycle. At TMO_CYC, go to RSP with rsp_resp = 2'b10 and rdata = 0. A late B/R arriving in IDLE is ignored with ready = 0.
- RSP: rsp_valid = 1, held with stable payload until rsp_ready, then return to IDLE. Next-request latency is ≥1 cycle.
- Valids never drop before their handshake, and payloads stay stable while valid.
- id_err clears only on reset.

Decomposition:
- Shared package `dbg_axi_pkg`:
  - FSM state enum
  - AXI response constants: OKAY = 2'b00, SLVERR = 2'b10
  - Debug address map: UART_TX 0x6000_0000, TIMER 0x6000_0008, COTRL 0x6000_0010, COTRL_COREMARK 0x6000_0020
- One sub-module, `dbg_req_fifo`: parameterised sync FIFO with push/pop, full/empty and head data (73 bits: wen, addr, wdata, wstrb, id).

Test Plan:
- Single write: req {wen=1, addr=0x60000000, wdata=0x41, wstrb=0xF, id=3}, slave raises AW/W ready together -> one AW+W beat, then BREADY; rsp_valid with rsp_id=3, rsp_resp=0, id_err=0.
- Skewed write: WREADY 2 cycles after AWREADY -> AWVALID drops after its handshake, WVALID held until its own; exactly one B consumed, one response.
- Read: req {wen=0, addr=0x60000008, id=5}, slave returns RDATA=0xDEADBEEF, RID=5 -> rsp_rdata=0xDEADBEEF, rsp_id=5, rsp_wen=0.
- FIFO full/backpressure: push 5 requests with rsp_ready=0 and FIFO_DP=4 -> req_ready=0 once 4 buffered (first in flight); after releasing rsp_ready, all 5 responses return in order with ids intact.
- Error paths:
  - BID=7 returned for id=2 -> id_err=1 and it stays 1.
  - With TMO_CYC=16 and BVALID never asserted -> response after 16 cycles with rsp_resp=2'b10.
- Reset mid-operation: assert RSTn=0 while in WR_B -> all valids and rsp_valid = 0 immediately; FIFO empty; post-reset request completes normally.
